// File: rtl/hough_pkg.sv
// hough_pkg
// Shared definitions for the Hough accumulator slice: parameter defaults,
// the accumulator FSM state enumeration and the saturation helper.
// No ports (package).

package hough_pkg;

    localparam int ACCUM_BUFF_SIZE_DEF = 32400;
    localparam int ADDR_BITS_DEF       = 16;
    localparam int ACCUM_BITS_DEF      = 8;

    typedef enum logic [2:0] {
        ACC_IDLE    = 3'd0,
        ACC_CLEAR   = 3'd1,
        ACC_ACCUM   = 3'd2,
        ACC_DRAIN   = 3'd3,
        ACC_READOUT = 3'd4,
        ACC_DONE    = 3'd5
    } accum_state_t;

    // Largest value a counter of the given width can hold.
    function automatic int accum_sat_max(int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/hough_accumulator_if.sv
// hough_accumulator_if
// Groups the vote-FIFO read side and the output-FIFO write side of the
// accumulator.
//   master : the accumulator (pops votes, pushes bins)
//   slave  : the FIFO environment around it
// Signals: vote_empty, vote_addr, vote_done, vote_rd_en,
//          out_full, out_wr_en, out_addr, out_data

interface hough_accumulator_if #(
    parameter int ADDR_BITS  = 16,
    parameter int ACCUM_BITS = 8
);
    logic                  vote_empty;
    logic [ADDR_BITS-1:0]  vote_addr;
    logic                  vote_done;
    logic                  vote_rd_en;
    logic                  out_full;
    logic                  out_wr_en;
    logic [ADDR_BITS-1:0]  out_addr;
    logic [ACCUM_BITS-1:0] out_data;

    modport master (
        input  vote_empty, vote_addr, vote_done, out_full,
        output vote_rd_en, out_wr_en, out_addr, out_data
    );

    modport slave (
        output vote_empty, vote_addr, vote_done, out_full,
        input  vote_rd_en, out_wr_en, out_addr, out_data
    );
endinterface

// File: rtl/hough_accum_ram.sv
// hough_accum_ram
// Simple dual-port RAM: one synchronous write port, one read port with
// one cycle of latency. A read of the address being written in the same
// cycle returns the old contents.
// Ports: clock, we/waddr/wdata (write), raddr/rdata (read).

module hough_accum_ram #(
    parameter int DEPTH  = 32400,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/hough_accumulator.sv
// hough_accumulator
// Pops bin indices from a first-word-fall-through vote FIFO, increments
// saturating per-bin counters held in RAM, then streams every bin out to
// an output FIFO. Each run clears the RAM first and ends with a done pulse.
// Ports: clock, reset (async, active-high), start, bus (vote/out FIFO
//        handshakes, master side), busy, done, overflow, bad_addr.
// Optional feature macro HOUGH_ACCUM_PEAK_EN adds peak_addr/peak_val, the
// first bin holding the largest count seen during readout.

module hough_accumulator
    import hough_pkg::*;
#(
    parameter int ACCUM_BUFF_SIZE = ACCUM_BUFF_SIZE_DEF,
    parameter int ADDR_BITS       = ADDR_BITS_DEF,
    parameter int ACCUM_BITS      = ACCUM_BITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    hough_accumulator_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
`ifdef HOUGH_ACCUM_PEAK_EN
    output logic [ADDR_BITS-1:0]  peak_addr,
    output logic [ACCUM_BITS-1:0] peak_val,
`endif
    output logic                  bad_addr
);
    localparam int RAM_AW = (ACCUM_BUFF_SIZE > 1) ? $clog2(ACCUM_BUFF_SIZE) : 1;
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(ACCUM_BUFF_SIZE - 1);
    localparam logic [ADDR_BITS:0]    SIZE_EXT  = (ADDR_BITS+1)'(ACCUM_BUFF_SIZE);
    localparam logic [ACCUM_BITS-1:0] SAT_MAX   = ACCUM_BITS'(accum_sat_max(ACCUM_BITS));

    localparam logic [2:0] ST_IDLE    = ACC_IDLE;
    localparam logic [2:0] ST_CLEAR   = ACC_CLEAR;
    localparam logic [2:0] ST_ACCUM   = ACC_ACCUM;
    localparam logic [2:0] ST_DRAIN   = ACC_DRAIN;
    localparam logic [2:0] ST_READOUT = ACC_READOUT;
    localparam logic [2:0] ST_DONE    = ACC_DONE;

    logic [2:0]            state;
    logic [ADDR_BITS-1:0]  addr_cnt;
    logic                  scan_done;
    logic                  pend_valid;
    logic [ADDR_BITS-1:0]  pend_addr;
    logic                  out_valid;
    logic                  s0_valid, s1_valid, wb_valid;
    logic [ADDR_BITS-1:0]  s0_addr, s1_addr, wb_addr;
    logic [ACCUM_BITS-1:0] s1_data, wb_data, base_val;
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_waddr, ram_raddr;
    logic [ACCUM_BITS-1:0] ram_wdata, ram_rdata;
    logic                  vote_pop, vote_ok, advance, last_push;

    assign vote_pop  = (state == ST_ACCUM) && !bus.vote_empty;
    assign vote_ok   = {1'b0, bus.vote_addr} < SIZE_EXT;
    // The output register can take a new bin when it is empty or being pushed.
    assign advance   = !out_valid || !bus.out_full;
    assign last_push = scan_done && !pend_valid && out_valid && !bus.out_full;

    assign bus.vote_rd_en = vote_pop;
    assign bus.out_wr_en  = (state == ST_READOUT) && out_valid && !bus.out_full;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE);

    // The RAM read issued with a vote may miss the two most recent writes:
    // the one still in S1 (lands this edge) and the one that landed on the
    // same edge the read sampled. Forward those, newest first.
    always_comb begin
        base_val = ram_rdata;
        if (s1_valid && (s1_addr == s0_addr))
            base_val = s1_data;
        else if (wb_valid && (wb_addr == s0_addr))
            base_val = wb_data;
    end

    // CLEAR owns the write port; otherwise S1 writes back. During readout
    // a stalled output re-reads the pending address so rdata stays valid.
    always_comb begin
        ram_we    = s1_valid;
        ram_waddr = s1_addr[RAM_AW-1:0];
        ram_wdata = s1_data;
        ram_raddr = bus.vote_addr[RAM_AW-1:0];
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = addr_cnt[RAM_AW-1:0];
            ram_wdata = '0;
        end
        if (state == ST_READOUT)
            ram_raddr = advance ? addr_cnt[RAM_AW-1:0] : pend_addr[RAM_AW-1:0];
    end

    hough_accum_ram #(
        .DEPTH  (ACCUM_BUFF_SIZE),
        .WIDTH  (ACCUM_BITS),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Read-modify-write pipeline and the sticky status flags. S0 waits for
    // the RAM read, S1 holds the incremented count being written back, and
    // the wb register remembers the previous write for forwarding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_addr  <= '0;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            overflow <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            s0_valid <= vote_pop && vote_ok;
            s0_addr  <= bus.vote_addr;
            s1_valid <= s0_valid;
            s1_addr  <= s0_addr;
            s1_data  <= (base_val == SAT_MAX) ? SAT_MAX : base_val + ACCUM_BITS'(1);
            wb_valid <= s1_valid;
            wb_addr  <= s1_addr;
            wb_data  <= s1_data;
            if ((state == ST_IDLE) && start) begin
                overflow <= 1'b0;
                bad_addr <= 1'b0;
            end else begin
                if (s0_valid && (base_val == SAT_MAX)) overflow <= 1'b1;
                if (vote_pop && !vote_ok)              bad_addr <= 1'b1;
            end
        end
    end

    // Run sequencing plus the readout scan. addr_cnt walks the RAM during
    // CLEAR and again during READOUT; pend_* tracks the bin whose data is
    // arriving on rdata, and the out register feeds the output FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            addr_cnt     <= '0;
            scan_done    <= 1'b0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            out_valid    <= 1'b0;
            bus.out_addr <= '0;
            bus.out_data <= '0;
`ifdef HOUGH_ACCUM_PEAK_EN
            peak_addr    <= '0;
            peak_val     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_cnt <= '0;
                        state    <= ST_CLEAR;
`ifdef HOUGH_ACCUM_PEAK_EN
                        peak_addr <= '0;
                        peak_val  <= '0;
`endif
                    end
                end
                ST_CLEAR: begin
                    if (addr_cnt == LAST_ADDR) begin
                        addr_cnt   <= '0;
                        scan_done  <= 1'b0;
                        pend_valid <= 1'b0;
                        out_valid  <= 1'b0;
                        state      <= ST_ACCUM;
                    end else begin
                        addr_cnt <= addr_cnt + ADDR_BITS'(1);
                    end
                end
                ST_ACCUM: begin
                    if (bus.vote_done && bus.vote_empty) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!s0_valid && !s1_valid) state <= ST_READOUT;
                end
                ST_READOUT: begin
`ifdef HOUGH_ACCUM_PEAK_EN
                    // Strictly greater keeps the lowest index on ties.
                    if (bus.out_wr_en && (bus.out_data > peak_val)) begin
                        peak_addr <= bus.out_addr;
                        peak_val  <= bus.out_data;
                    end
`endif
                    if (advance) begin
                        out_valid <= pend_valid;
                        if (pend_valid) begin
                            bus.out_addr <= pend_addr;
                            bus.out_data <= ram_rdata;
                        end
                        if (!scan_done) begin
                            pend_valid <= 1'b1;
                            pend_addr  <= addr_cnt;
                            if (addr_cnt == LAST_ADDR) scan_done <= 1'b1;
                            else                       addr_cnt  <= addr_cnt + ADDR_BITS'(1);
                        end else begin
                            pend_valid <= 1'b0;
                        end
                    end
                    if (last_push) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hough_accumulator.sv
// tb_hough_accumulator
// Self-checking bench for hough_accumulator with 16 bins, 5-bit vote
// addresses (so 16..31 are out of range) and 4-bit counters. The vote FIFO
// is a queue in the bench; every readout is compared bin by bin with a
// histogram built directly from the vote list. Peak outputs are checked
// when HOUGH_ACCUM_PEAK_EN is defined.

module tb_hough_accumulator;
    localparam int N    = 16;
    localparam int AB   = 5;
    localparam int CB   = 4;
    localparam int MAXV = 15;

    logic clock = 1'b0;
    logic reset, start, busy, done, overflow, bad_addr;
`ifdef HOUGH_ACCUM_PEAK_EN
    logic [AB-1:0] peak_addr;
    logic [CB-1:0] peak_val;
`endif

    hough_accumulator_if #(.ADDR_BITS(AB), .ACCUM_BITS(CB)) bus ();

    hough_accumulator #(
        .ACCUM_BUFF_SIZE (N),
        .ADDR_BITS       (AB),
        .ACCUM_BITS      (CB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
`ifdef HOUGH_ACCUM_PEAK_EN
        .peak_addr (peak_addr),
        .peak_val  (peak_val),
`endif
        .bad_addr  (bad_addr)
    );

    always #5 clock = ~clock;

    int unsigned  vq[$];
    int unsigned  stim_votes[$];
    logic [31:0]  pushed_addr[$];
    logic [31:0]  pushed_data[$];
    int           exp_bins[N];
    int           exp_ovf, exp_bad;
    int           done_count;
    bit           pop_next, bp_mode, rand_bp;
    int           bp_cnt;
    int           errors = 0;
    int           checks = 0;

    task automatic refresh_fifo();
        bus.vote_empty = (vq.size() == 0);
        bus.vote_addr  = (vq.size() > 0) ? AB'(vq[0]) : '0;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Monitor: sample handshakes mid-cycle.
    always @(negedge clock) begin
        pop_next = bus.vote_rd_en;
        if (bus.out_wr_en) begin
            pushed_addr.push_back(32'(bus.out_addr));
            pushed_data.push_back(32'(bus.out_data));
        end
        if (done === 1'b1) done_count++;
    end

    // FIFO and backpressure driver, updated just after each rising edge.
    always @(posedge clock) begin
        if (pop_next && vq.size() > 0) void'(vq.pop_front());
        #1;
        if (bp_mode) begin
            bp_cnt++;
            if (bp_cnt == 3) begin
                bp_cnt = 0;
                bus.out_full = ~bus.out_full;
            end
        end else if (rand_bp) begin
            bus.out_full = ($urandom_range(0, 3) == 0);
        end else begin
            bus.out_full = 1'b0;
        end
        refresh_fifo();
    end

    task automatic build_model();
        foreach (exp_bins[i]) exp_bins[i] = 0;
        exp_ovf = 0;
        exp_bad = 0;
        foreach (stim_votes[k]) begin
            if (stim_votes[k] >= N)               exp_bad = 1;
            else if (exp_bins[stim_votes[k]] == MAXV) exp_ovf = 1;
            else                                  exp_bins[stim_votes[k]]++;
        end
    endtask

    task automatic check_output(input string name);
        check({name, "_done_pulses"}, 32'(done_count), 1);
        check({name, "_push_count"}, 32'(pushed_addr.size()), N);
        for (int i = 0; i < N; i++) begin
            if (i < pushed_addr.size()) begin
                check($sformatf("%s_push%0d_addr", name, i), pushed_addr[i], 32'(i));
                check($sformatf("%s_bin%0d", name, i), pushed_data[i], 32'(exp_bins[i]));
            end
        end
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, "_bad_addr"}, 32'(bad_addr), 32'(exp_bad));
        check({name, "_busy_after"}, 32'(busy), 0);
`ifdef HOUGH_ACCUM_PEAK_EN
        begin
            int pa = 0;
            int pv = 0;
            for (int i = 0; i < N; i++)
                if (exp_bins[i] > pv) begin
                    pa = i;
                    pv = exp_bins[i];
                end
            check({name, "_peak_addr"}, 32'(peak_addr), 32'(pa));
            check({name, "_peak_val"}, 32'(peak_val), 32'(pv));
        end
`endif
    endtask

    task automatic apply_stimulus(input string name, input bit trickle);
        build_model();
        pushed_addr.delete();
        pushed_data.delete();
        done_count = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        if (!trickle) begin
            foreach (stim_votes[k]) vq.push_back(stim_votes[k]);
            refresh_fifo();
            bus.vote_done = 1'b1;
        end else begin
            bus.vote_done = 1'b0;
            repeat (N + 2) @(posedge clock);
            #1;
            foreach (stim_votes[k]) begin
                repeat ($urandom_range(0, 2)) @(posedge clock);
                #1;
                vq.push_back(stim_votes[k]);
                refresh_fifo();
            end
            bus.vote_done = 1'b1;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            if (done_count > 0) break;
        end
        repeat (2) @(posedge clock);
        #1 bus.vote_done = 1'b0;
        @(negedge clock);
        check_output(name);
    endtask

    task automatic random_votes(input int lo, input int hi);
        int len;
        stim_votes.delete();
        len = $urandom_range(6, 12);
        for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) == 0) stim_votes.push_back($urandom_range(N, 31));
            else                           stim_votes.push_back($urandom_range(lo, hi));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.vote_done = 1'b0;
        bus.out_full = 1'b0;
        bp_mode = 0;
        rand_bp = 0;
        bp_cnt = 0;
        done_count = 0;
        refresh_fifo();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_vote_rd_en", 32'(bus.vote_rd_en), 0);
        check("rst_out_wr_en", 32'(bus.out_wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_bad_addr", 32'(bad_addr), 0);
        check("rst_out_addr", 32'(bus.out_addr), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        @(posedge clock); #1 reset = 1'b0;

        $display("[TB] basic voting");
        stim_votes = '{3, 5, 3};
        apply_stimulus("basic", 0);

        $display("[TB] back-to-back hazard");
        stim_votes.delete();
        for (int k = 0; k < 10; k++) stim_votes.push_back(7);
        apply_stimulus("hazard", 0);

        $display("[TB] saturation");
        stim_votes.delete();
        for (int k = 0; k < 20; k++) stim_votes.push_back(2);
        apply_stimulus("saturate", 0);

        $display("[TB] backpressure");
        stim_votes = '{0, 15, 8, 8, 1};
        bp_mode = 1;
        bp_cnt = 0;
        apply_stimulus("backpressure", 0);
        bp_mode = 0;

        $display("[TB] bad address");
        stim_votes = '{16};
        apply_stimulus("bad", 0);

`ifdef HOUGH_ACCUM_PEAK_EN
        $display("[TB] peak tracking");
        stim_votes = '{4, 9, 9, 4};
        apply_stimulus("peak", 0);
`endif

        $display("[TB] random runs");
        random_votes(0, 3);
        apply_stimulus("rand_dense", 0);
        random_votes(0, N - 1);
        apply_stimulus("rand_wide", 0);
        random_votes(0, 5);
        rand_bp = 1;
        apply_stimulus("rand_trickle", 1);
        rand_bp = 0;

        $display("[TB] reset mid-accumulate");
        stim_votes = '{1, 20, 1};
        build_model();
        bus.vote_done = 1'b0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        foreach (stim_votes[k]) vq.push_back(stim_votes[k]);
        refresh_fifo();
        repeat (N + 8) @(posedge clock);
        @(negedge clock);
        check("midrst_busy_before", 32'(busy), 1);
        check("midrst_bad_before", 32'(bad_addr), 1);
        @(posedge clock); #1;
        vq.push_back(4);
        vq.push_back(5);
        vq.push_back(6);
        vq.push_back(7);
        refresh_fifo();
        reset = 1'b1;
        @(negedge clock);
        check("midrst_vote_rd_en", 32'(bus.vote_rd_en), 0);
        check("midrst_out_wr_en", 32'(bus.out_wr_en), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_bad_addr", 32'(bad_addr), 0);
        check("midrst_overflow", 32'(overflow), 0);
        check("midrst_out_addr", 32'(bus.out_addr), 0);
        check("midrst_out_data", 32'(bus.out_data), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("midrst_no_pops", 32'(vq.size()), 4);
        @(posedge clock); #1 reset = 1'b0;
        vq.delete();
        refresh_fifo();
        stim_votes = '{1, 1, 2, 1, 9};
        apply_stimulus("after_reset", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
